// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: drains the two-entry key-code buffer onto a write-only
// SPI link (mode 0, MSB first), one 8-bit frame per pending byte.
//
// Handshake: status_ctr != 0 is the buffer's valid, and d is its payload.
// The sequencer accepts a byte only on the IDLE edge where en is high and
// valid is seen. It then issues exactly one transfer_done pulse per accepted
// byte, which the buffer treats as its pop strobe. Between acceptance and
// transfer_done, d and status_ctr are ignored.
module spi_tx_sequencer #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst_bar,
  input  logic       en,
  input  logic [1:0] status_ctr,
  input  logic [7:0] d,
  output logic       transfer_done,
  output logic       cs_n,
  output logic       sclk,
  output logic       mosi,
  output logic       active,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One phase counter serves SETUP, both sclk half-periods and HOLD, so it
  // must reach the largest of the three durations minus one.
  localparam int PMAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PMAX    = (CLK_DIV > PMAX_SH) ? CLK_DIV : PMAX_SH;
  localparam int PW      = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [PW-1:0] DIV_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [PW-1:0] phase;

  // mosi is the shift register MSB: it is a flop, loads d[7] at frame start,
  // advances on each sclk fall and reaches 0 after the eighth shift.
  assign mosi      = shreg[7];
  assign state_dbg = state;

  // Frame FSM: state, counters and every SPI-side output register.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state         <= ST_IDLE;
      shreg         <= 8'h00;
      bit_cnt       <= 3'd0;
      phase         <= '0;
      cs_n          <= 1'b1;
      sclk          <= 1'b0;
      active        <= 1'b0;
      transfer_done <= 1'b0;
    end else begin
      // transfer_done is only ever set on the HOLD->DONE edge, so clearing
      // it by default keeps it to a single-cycle pulse.
      transfer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk <= 1'b0;
          cs_n <= 1'b1;
          if (en && (status_ctr != 2'd0)) begin
            shreg  <= d;
            cs_n   <= 1'b0;
            active <= 1'b1;
            phase  <= '0;
            state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          sclk <= 1'b0;
          if (phase == SETUP_LAST) begin
            phase   <= '0;
            bit_cnt <= 3'd0;
            state   <= ST_SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (phase != DIV_LAST) begin
            phase <= phase + 1'b1;
          end else if (!sclk) begin
            // End of low phase: rising edge, slave samples mosi.
            phase <= '0;
            sclk  <= 1'b1;
          end else begin
            // End of high phase: falling edge, present the next bit.
            phase <= '0;
            sclk  <= 1'b0;
            shreg <= {shreg[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              state <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        ST_HOLD: begin
          sclk <= 1'b0;
          if (phase == HOLD_LAST) begin
            phase         <= '0;
            cs_n          <= 1'b1;
            transfer_done <= 1'b1;
            state         <= ST_DONE;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_DONE: begin
          // The buffer pops on the edge that leaves DONE, so IDLE always
          // sees the refreshed count and head byte.
          cs_n   <= 1'b1;
          sclk   <= 1'b0;
          active <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          cs_n   <= 1'b1;
          sclk   <= 1'b0;
          active <= 1'b0;
          shreg  <= 8'h00;
          phase  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Testbench for spi_tx_sequencer: default-timing instance fed by a
// two-entry buffer model, plus a CLK_DIV=CS_SETUP=CS_HOLD=1 instance.
module tb_spi_tx_sequencer;

  localparam int A_DIV = 2, A_SETUP = 2, A_HOLD = 2;
  localparam int A_FRAME = A_SETUP + 16 * A_DIV + A_HOLD;
  localparam int B_DIV = 1, B_SETUP = 1, B_HOLD = 1;
  localparam int B_FRAME = B_SETUP + 16 * B_DIV + B_HOLD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_bar;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       en_a, en_b;
  logic [1:0] status_a, status_b;
  logic [7:0] d_a, d_b;
  logic       done_a, cs_n_a, sclk_a, mosi_a, active_a;
  logic       done_b, cs_n_b, sclk_b, mosi_b, active_b;
  logic [2:0] state_dbg_a, state_dbg_b;

  spi_tx_sequencer #(.CLK_DIV(A_DIV), .CS_SETUP(A_SETUP), .CS_HOLD(A_HOLD)) dut_a (
    .clk(clk), .rst_bar(rst_bar), .en(en_a), .status_ctr(status_a), .d(d_a),
    .transfer_done(done_a), .cs_n(cs_n_a), .sclk(sclk_a), .mosi(mosi_a),
    .active(active_a), .state_dbg(state_dbg_a)
  );

  spi_tx_sequencer #(.CLK_DIV(B_DIV), .CS_SETUP(B_SETUP), .CS_HOLD(B_HOLD)) dut_b (
    .clk(clk), .rst_bar(rst_bar), .en(en_b), .status_ctr(status_b), .d(d_b),
    .transfer_done(done_b), .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b),
    .active(active_b), .state_dbg(state_dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] buf_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  int         buf_b_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic buf_sync_a();
    status_a = 2'(buf_q.size());
    d_a      = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
  endtask

  task automatic push_a(input logic [7:0] b);
    buf_q.push_back(b);
    exp_q.push_back(b);
    buf_sync_a();
  endtask

  task automatic push_b();
    buf_b_cnt++;
    exp_b_q.push_back(8'hFF);
    status_b = 2'(buf_b_cnt);
  endtask

  // ---------------- monitors (sample on falling edge) ----------------
  logic [7:0] rx_a, rx_b;
  int bits_a, bits_b, cs_low_a, cs_low_b, hi_w_a, since_rise_a, since_rise_b;
  int act_len_a, toggles_a, done_cnt_a, done_cnt_b;
  bit rise_seen_a, rise_seen_b;
  logic prev_cs_a, prev_sclk_a, prev_mosi_a, prev_done_a, prev_act_a;
  logic prev_cs_b, prev_sclk_b, prev_done_b;

  // DUT A monitor and buffer pop
  always @(negedge clk) begin
    if (!rst_bar) begin
      rx_a = 8'h00; bits_a = 0; cs_low_a = 0; hi_w_a = 0; since_rise_a = 0;
      act_len_a = 0; rise_seen_a = 0;
      prev_cs_a = 1'b1; prev_sclk_a = 1'b0; prev_mosi_a = 1'b0;
      prev_done_a = 1'b0; prev_act_a = 1'b0;
    end else begin
      since_rise_a++;
      if (done_a) begin
        done_cnt_a++;
        check_eq("a_done_gap", 32'(prev_done_a), 32'd0);
        check_eq("a_done_after_cs_rise", 32'({prev_cs_a, cs_n_a}), 32'b01);
        check_eq("a_cs_low_len", 32'(cs_low_a), 32'(A_FRAME));
        check_eq("a_bit_count", 32'(bits_a), 32'd8);
        if (exp_q.size() == 0) check_eq("a_unexpected_done", 32'd1, 32'd0);
        else check_eq("a_byte", 32'(rx_a), 32'(exp_q.pop_front()));
        if (buf_q.size() != 0) void'(buf_q.pop_front());
        buf_sync_a();
        cs_low_a = 0; bits_a = 0; rise_seen_a = 0;
      end
      if (sclk_a && !prev_sclk_a) begin
        rx_a = {rx_a[6:0], mosi_a};
        bits_a++;
        if (rise_seen_a) check_eq("a_sclk_period", 32'(since_rise_a), 32'(2 * A_DIV));
        since_rise_a = 0;
        rise_seen_a = 1;
      end
      if (!sclk_a && prev_sclk_a) check_eq("a_sclk_high", 32'(hi_w_a), 32'(A_DIV));
      hi_w_a = sclk_a ? hi_w_a + 1 : 0;
      if (!cs_n_a) cs_low_a++;
      if (!active_a && prev_act_a) check_eq("a_active_len", 32'(act_len_a), 32'(A_FRAME + 1));
      act_len_a = active_a ? act_len_a + 1 : 0;
      toggles_a += int'(cs_n_a != prev_cs_a) + int'(sclk_a != prev_sclk_a)
                 + int'(mosi_a != prev_mosi_a) + int'(done_a != prev_done_a);
      prev_cs_a = cs_n_a; prev_sclk_a = sclk_a; prev_mosi_a = mosi_a;
      prev_done_a = done_a; prev_act_a = active_a;
    end
  end

  // DUT B monitor and buffer pop
  always @(negedge clk) begin
    if (!rst_bar) begin
      rx_b = 8'h00; bits_b = 0; cs_low_b = 0; since_rise_b = 0; rise_seen_b = 0;
      prev_cs_b = 1'b1; prev_sclk_b = 1'b0; prev_done_b = 1'b0;
    end else begin
      since_rise_b++;
      if (done_b) begin
        done_cnt_b++;
        check_eq("b_done_gap", 32'(prev_done_b), 32'd0);
        check_eq("b_done_after_cs_rise", 32'({prev_cs_b, cs_n_b}), 32'b01);
        check_eq("b_cs_low_len", 32'(cs_low_b), 32'(B_FRAME));
        check_eq("b_bit_count", 32'(bits_b), 32'd8);
        if (exp_b_q.size() == 0) check_eq("b_unexpected_done", 32'd1, 32'd0);
        else check_eq("b_byte", 32'(rx_b), 32'(exp_b_q.pop_front()));
        if (buf_b_cnt != 0) buf_b_cnt--;
        status_b = 2'(buf_b_cnt);
        cs_low_b = 0; bits_b = 0; rise_seen_b = 0;
      end
      if (sclk_b && !prev_sclk_b) begin
        rx_b = {rx_b[6:0], mosi_b};
        bits_b++;
        check_eq("b_mosi_at_rise", 32'(mosi_b), 32'd1);
        if (rise_seen_b) check_eq("b_sclk_period", 32'(since_rise_b), 32'(2 * B_DIV));
        since_rise_b = 0;
        rise_seen_b = 1;
      end
      if (!cs_n_b) cs_low_b++;
      prev_cs_b = cs_n_b; prev_sclk_b = sclk_b; prev_done_b = done_b;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done_a(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < budget);
    if (!done_a) check_eq("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done_b(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_b && n < budget);
    if (!done_b) check_eq("b_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs_n"}, 32'(cs_n_a), 32'd1);
    check_eq({tag, "_sclk"}, 32'(sclk_a), 32'd0);
    check_eq({tag, "_mosi"}, 32'(mosi_a), 32'd0);
    check_eq({tag, "_done"}, 32'(done_a), 32'd0);
    check_eq({tag, "_active"}, 32'(active_a), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, bad, snap, t0;
    en_a = 1'b0; en_b = 1'b0; d_b = 8'hFF; status_b = 2'd0; buf_b_cnt = 0;
    toggles_a = 0; done_cnt_a = 0; done_cnt_b = 0;
    buf_sync_a();
    rst_bar = 1'b1;
    #1 rst_bar = 1'b0;
    #2 check_reset_outputs("reset");
    check_eq("reset_b_cs_n", 32'(cs_n_b), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_bar = 1'b1;
    @(negedge clk);

    // single byte 0xA5 with defaults
    en_a = 1'b1;
    push_a(8'hA5);
    wait_done_a(100);
    repeat (4) @(negedge clk);

    // back-to-back: 0x03 then 0x0C, cs_n high exactly 2 cycles between frames
    snap = done_cnt_a;
    push_a(8'h03);
    push_a(8'h0C);
    wait_done_a(100);
    n = 1;
    while (cs_n_a && n < 20) begin
      @(negedge clk);
      if (cs_n_a) n++;
    end
    check_eq("b2b_cs_high_gap", 32'(n), 32'd2);
    wait_done_a(100);
    repeat (3) @(negedge clk);
    check_eq("b2b_done_count", 32'(done_cnt_a - snap), 32'd2);
    check_eq("b2b_status_empty", 32'(status_a), 32'd0);
    check_eq("b2b_idle_active", 32'(active_a), 32'd0);

    // enable gating
    en_a = 1'b0;
    push_a(8'h96);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!cs_n_a || active_a) bad++;
    end
    check_eq("gate_quiet_cycles", 32'(bad), 32'd0);
    en_a = 1'b1;
    @(negedge clk);
    check_eq("gate_start_cs_n", 32'(cs_n_a), 32'd0);
    check_eq("gate_start_active", 32'(active_a), 32'd1);
    repeat (10) @(negedge clk);
    en_a = 1'b0;
    wait_done_a(100);
    repeat (3) @(negedge clk);
    en_a = 1'b1;

    // reset during SHIFT bit 4, then a full fresh frame
    push_a(8'h5A);
    n = 0;
    while (cs_n_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_frame_started", 32'(cs_n_a), 32'd0);
    repeat (20) @(negedge clk);
    snap = done_cnt_a;
    #3 rst_bar = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check_eq("rst_no_done", 32'(done_cnt_a - snap), 32'd0);
    #3 rst_bar = 1'b1;
    wait_done_a(100);
    repeat (3) @(negedge clk);
    check_eq("rst_refetch_done_count", 32'(done_cnt_a - snap), 32'd1);

    // random bytes, one or two at a time
    repeat (4) begin
      n = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) push_a(8'($urandom_range(0, 255)));
      for (int i = 0; i < n; i++) wait_done_a(100);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    // idle quiet
    repeat (3) @(negedge clk);
    t0 = toggles_a;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (active_a) bad++;
    end
    check_eq("idle_toggles", 32'(toggles_a - t0), 32'd0);
    check_eq("idle_active", 32'(bad), 32'd0);

    // CLK_DIV = CS_SETUP = CS_HOLD = 1 instance, d = 0xFF
    en_b = 1'b1;
    push_b();
    wait_done_b(60);
    repeat (3) @(negedge clk);
    check_eq("b_done_count", 32'(done_cnt_b), 32'd1);

    check_eq("a_exp_q_drained", 32'(exp_q.size()), 32'd0);
    check_eq("b_exp_q_drained", 32'(exp_b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
